// File: rtl/kernel_stream_feeder.sv
// Source-side feeder for the generated kernel: buffers packed 4-lane upstream words
// in a small FIFO and issues exactly nelems elements on the u/x/v/y kernel streams.
module kernel_stream_feeder #(
    parameter int STREAMW = 34,
    parameter int DEPTH   = 4,
    parameter int CNTW    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNTW-1:0]        nelems,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [4*STREAMW-1:0]   s_data,
    output logic                   ivalid_u_s0,
    output logic                   ivalid_x_s0,
    output logic                   ivalid_v_s0,
    output logic                   ivalid_y_s0,
    output logic [STREAMW-1:0]     u_s0,
    output logic [STREAMW-1:0]     x_s0,
    output logic [STREAMW-1:0]     v_s0,
    output logic [STREAMW-1:0]     y_s0,
    input  logic                   iready,
    output logic                   busy,
    output logic                   done,
    output logic [CNTW-1:0]        count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t                 state;
    logic [4*STREAMW-1:0]   mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            occ;
    logic [CNTW-1:0]        acc_left;
    logic [CNTW-1:0]        iss_left;
    logic                   empty;
    logic                   full;
    logic                   ivalid;
    logic                   push;
    logic                   pop;
    logic [4*STREAMW-1:0]   head;

    // Handshakes depend only on registered state, never on s_valid or iready.
    assign empty   = (occ == '0);
    assign full    = (occ == FULL_OCC);
    assign s_ready = (state == RUN) && !full && (acc_left != '0);
    assign ivalid  = (state == RUN) && !empty;
    assign push    = s_valid && s_ready;
    assign pop     = ivalid && iready;

    assign ivalid_u_s0 = ivalid;
    assign ivalid_x_s0 = ivalid;
    assign ivalid_v_s0 = ivalid;
    assign ivalid_y_s0 = ivalid;

    assign head = mem[rd_ptr];
    assign u_s0 = head[STREAMW-1:0];
    assign x_s0 = head[2*STREAMW-1:STREAMW];
    assign v_s0 = head[3*STREAMW-1:2*STREAMW];
    assign y_s0 = head[4*STREAMW-1:3*STREAMW];

    // Storage is cleared on reset so an aborted run leaves nothing on the lanes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc_left <= '0;
            iss_left <= '0;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (push) begin
                acc_left <= acc_left - CNTW'(1);
            end
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc_left <= nelems;
                        iss_left <= nelems;
                        count    <= '0;
                        if (nelems == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pop) begin
                        iss_left <= iss_left - CNTW'(1);
                        count    <= count + CNTW'(1);
                        if (iss_left == CNTW'(1)) begin
                            state <= FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kernel_stream_feeder.sv
// Directed bench for kernel_stream_feeder: reset, basic run, backpressure, FIFO full,
// zero-length and ignored starts, and abort by reset mid-run.
module tb_kernel_stream_feeder;

    localparam int STREAMW = 34;
    localparam int DEPTH   = 4;
    localparam int CNTW    = 32;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   start = 1'b0;
    logic [CNTW-1:0]        nelems = '0;
    logic                   s_valid = 1'b0;
    logic                   s_ready;
    logic [4*STREAMW-1:0]   s_data = '0;
    logic                   ivalid_u_s0, ivalid_x_s0, ivalid_v_s0, ivalid_y_s0;
    logic [STREAMW-1:0]     u_s0, x_s0, v_s0, y_s0;
    logic                   iready = 1'b0;
    logic                   busy;
    logic                   done;
    logic [CNTW-1:0]        count;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    int word_idx  = 0;
    int accepts   = 0;

    kernel_stream_feeder #(.STREAMW(STREAMW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .start(start), .nelems(nelems),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .ivalid_u_s0(ivalid_u_s0), .ivalid_x_s0(ivalid_x_s0),
        .ivalid_v_s0(ivalid_v_s0), .ivalid_y_s0(ivalid_y_s0),
        .u_s0(u_s0), .x_s0(x_s0), .v_s0(v_s0), .y_s0(y_s0),
        .iready(iready), .busy(busy), .done(done), .count(count)
    );

    always #5 clk = ~clk;

    // Word k carries u=k+1, x=0x10+k, v=0x20+k, y=0x30+k.
    function automatic logic [4*STREAMW-1:0] make_word(int k);
        logic [STREAMW-1:0] u, x, v, y;
        u = STREAMW'(k + 1);
        x = STREAMW'(32'h10 + k);
        v = STREAMW'(32'h20 + k);
        y = STREAMW'(32'h30 + k);
        return {y, v, x, u};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advances one cycle; the upstream source moves to the next word after each accept.
    task automatic tick();
        logic acc;
        acc = s_valid && s_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            accepts++;
            word_idx++;
            s_data = make_word(word_idx);
        end
    endtask

    task automatic begin_run(input int n);
        word_idx = 0;
        accepts  = 0;
        s_data   = make_word(0);
        nelems   = CNTW'(n);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic check_lanes(input string tag, input int k);
        check({tag, "_iv_u"}, 64'(ivalid_u_s0), 64'd1);
        check({tag, "_iv_x"}, 64'(ivalid_x_s0), 64'd1);
        check({tag, "_iv_v"}, 64'(ivalid_v_s0), 64'd1);
        check({tag, "_iv_y"}, 64'(ivalid_y_s0), 64'd1);
        check({tag, "_u"}, 64'(u_s0), 64'(k + 1));
        check({tag, "_x"}, 64'(x_s0), 64'(32'h10 + k));
        check({tag, "_v"}, 64'(v_s0), 64'(32'h20 + k));
        check({tag, "_y"}, 64'(y_s0), 64'(32'h30 + k));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
        check({tag, "_iv_u"}, 64'(ivalid_u_s0), 64'd0);
        check({tag, "_iv_x"}, 64'(ivalid_x_s0), 64'd0);
        check({tag, "_iv_v"}, 64'(ivalid_v_s0), 64'd0);
        check({tag, "_iv_y"}, 64'(ivalid_y_s0), 64'd0);
        check({tag, "_u"}, 64'(u_s0), 64'd0);
        check({tag, "_x"}, 64'(x_s0), 64'd0);
        check({tag, "_v"}, 64'(v_s0), 64'd0);
        check({tag, "_y"}, 64'(y_s0), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_count"}, 64'(count), 64'd0);
    endtask

    initial begin
        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1 check_zero("rst_async");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check_zero("post_rst_a");
        tick();
        check_zero("post_rst_b");

        // Basic run of three elements with the kernel always ready.
        s_valid = 1'b1;
        iready  = 1'b1;
        begin_run(3);
        check("basic_busy", 64'(busy), 64'd1);
        check("basic_no_iv_yet", 64'(ivalid_u_s0), 64'd0);
        tick();
        check_lanes("basic_e0", 0);
        check("basic_cnt0", 64'(count), 64'd0);
        tick();
        check_lanes("basic_e1", 1);
        check("basic_cnt1", 64'(count), 64'd1);
        tick();
        check_lanes("basic_e2", 2);
        check("basic_sready_stop", 64'(s_ready), 64'd0);
        tick();
        check("basic_done", 64'(done), 64'd1);
        check("basic_count", 64'(count), 64'd3);
        check("basic_iv_off", 64'(ivalid_u_s0), 64'd0);
        check("basic_busy_off", 64'(busy), 64'd0);
        tick();
        check("basic_done_once", 64'(done), 64'd0);
        check("basic_sready_after", 64'(s_ready), 64'd0);
        check("basic_count_hold", 64'(count), 64'd3);
        check("basic_accepts", 64'(accepts), 64'd3);

        // Backpressure: head must hold steady while the kernel stalls.
        iready = 1'b0;
        begin_run(2);
        tick();
        for (int i = 0; i < 5; i++) begin
            check_lanes("bp_hold", 0);
            tick();
        end
        check_lanes("bp_hold_last", 0);
        check("bp_cnt_stalled", 64'(count), 64'd0);
        iready = 1'b1;
        tick();
        check_lanes("bp_after", 1);
        check("bp_cnt1", 64'(count), 64'd1);
        tick();
        check("bp_done", 64'(done), 64'd1);
        check("bp_count", 64'(count), 64'd2);
        tick();
        check("bp_done_once", 64'(done), 64'd0);

        // FIFO full: four accepts then refusal, then an in-order drain of eight.
        iready = 1'b0;
        begin_run(8);
        repeat (4) tick();
        check("full_sready", 64'(s_ready), 64'd0);
        check("full_accepts", 64'(accepts), 64'd4);
        repeat (2) begin
            tick();
            check("full_sready_hold", 64'(s_ready), 64'd0);
            check("full_accepts_hold", 64'(accepts), 64'd4);
            check_lanes("full_head", 0);
        end
        iready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check_lanes("full_drain", k);
            check("full_no_done", 64'(done), 64'd0);
            tick();
        end
        check("full_done", 64'(done), 64'd1);
        check("full_count", 64'(count), 64'd8);
        check("full_accepts_total", 64'(accepts), 64'd8);
        tick();
        check("full_done_once", 64'(done), 64'd0);

        // Zero-length run goes straight to done and clears the previous count.
        begin_run(0);
        check("zero_done", 64'(done), 64'd1);
        check("zero_iv", 64'(ivalid_u_s0), 64'd0);
        check("zero_count", 64'(count), 64'd0);
        check("zero_busy", 64'(busy), 64'd0);
        tick();
        check("zero_done_once", 64'(done), 64'd0);
        check("zero_iv_after", 64'(ivalid_u_s0), 64'd0);

        // A start pulse during RUN must not reload the run.
        begin_run(3);
        tick();
        check_lanes("ign_e0", 0);
        start  = 1'b1;
        nelems = CNTW'(5);
        tick();
        start  = 1'b0;
        check_lanes("ign_e1", 1);
        check("ign_cnt1", 64'(count), 64'd1);
        check("ign_busy", 64'(busy), 64'd1);
        tick();
        check_lanes("ign_e2", 2);
        check("ign_cnt2", 64'(count), 64'd2);
        tick();
        check("ign_done", 64'(done), 64'd1);
        check("ign_count", 64'(count), 64'd3);
        tick();
        check("ign_done_once", 64'(done), 64'd0);

        // Reset mid-run aborts without done, then a fresh run completes.
        begin_run(6);
        repeat (4) tick();
        check("mid_cnt3", 64'(count), 64'd3);
        check_lanes("mid_e3", 3);
        #2 rst = 1'b1;
        #1 check_zero("mid_rst");
        s_valid = 1'b0;
        tick();
        check("mid_rst_no_done", 64'(done), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check_zero("mid_after_rst");
        s_valid = 1'b1;
        begin_run(2);
        tick();
        check_lanes("fresh_e0", 0);
        tick();
        check_lanes("fresh_e1", 1);
        check("fresh_cnt1", 64'(count), 64'd1);
        tick();
        check("fresh_done", 64'(done), 64'd1);
        check("fresh_count", 64'(count), 64'd2);
        tick();
        check("fresh_done_once", 64'(done), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
